// File: rtl/spi_flash_loader.sv
// ============================================================================
// Module  : spi_flash_loader
// Brief   : Copies a byte range from SPI NOR flash (READ 0x03, mode 0) into
//           the cache write port, with partial-word strobes and abort.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_flash_loader #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int LEN_WIDTH    = 24,
  parameter int CLK_DIV      = 1,
  parameter int STARTUP_WAIT = 1_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [23:0]             src_addr,
  input  logic [ADDR_WIDTH-1:0]   dst_addr,
  input  logic [LEN_WIDTH-1:0]    byte_count,
  output logic                    ready,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   cache_address,
  output logic [DATA_WIDTH-1:0]   cache_data_in,
  output logic [DATA_WIDTH/8-1:0] cache_write_enable,
  input  logic                    cache_busy,
  output logic                    flash_clk,
  output logic                    flash_mosi,
  output logic                    flash_cs,
  input  logic                    flash_miso
);

  localparam int         c_BYTES     = DATA_WIDTH / 8;
  localparam int         c_LANE_W    = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
  localparam int         c_DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int         c_WAIT_W    = (STARTUP_WAIT > 1) ? $clog2(STARTUP_WAIT) : 1;
  localparam int         c_WAIT_LAST = (STARTUP_WAIT > 0) ? STARTUP_WAIT - 1 : 0;
  localparam logic [7:0] c_CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    S_POWERUP = 3'd0,
    S_IDLE    = 3'd1,
    S_CMD     = 3'd2,
    S_ADDR    = 3'd3,
    S_READ    = 3'd4,
    S_WRITE   = 3'd5,
    S_FINISH  = 3'd6
  } state_t;

  state_t                  r_state;
  logic [c_WAIT_W-1:0]     r_wait_cnt;
  logic [c_DIV_W-1:0]      r_div_cnt;
  logic [4:0]              r_bit_cnt;
  logic [31:0]             r_tx;
  logic [7:0]              r_rx;
  logic [c_LANE_W-1:0]     r_lane;
  logic [DATA_WIDTH-1:0]   r_word;
  logic [LEN_WIDTH-1:0]    r_remaining;
  logic [ADDR_WIDTH-1:0]   r_dst;

  logic                    w_half_done;
  logic                    w_spi_state;
  logic [DATA_WIDTH-1:0]   w_word_next;
  logic [c_BYTES-1:0]      w_strobe;

  assign w_half_done = (r_div_cnt == c_DIV_W'(CLK_DIV - 1));
  assign w_spi_state = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_READ);

  // r_rx already holds the complete byte on the falling edge that ends it.
  always_comb begin
    w_word_next = r_word;
    w_strobe    = '0;
    for (int i = 0; i < c_BYTES; i++) begin
      if (c_LANE_W'(i) == r_lane) w_word_next[i*8 +: 8] = r_rx;
      w_strobe[i] = (c_LANE_W'(i) <= r_lane);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= S_POWERUP;
      r_wait_cnt         <= '0;
      r_div_cnt          <= '0;
      r_bit_cnt          <= '0;
      r_tx               <= '0;
      r_rx               <= '0;
      r_lane             <= '0;
      r_word             <= '0;
      r_remaining        <= '0;
      r_dst              <= '0;
      ready              <= 1'b0;
      done               <= 1'b0;
      cache_address      <= '0;
      cache_data_in      <= '0;
      cache_write_enable <= '0;
      flash_clk          <= 1'b0;
      flash_mosi         <= 1'b0;
      flash_cs           <= 1'b1;
    end else begin
      done <= 1'b0;
      if (abort && (w_spi_state || r_state == S_WRITE)) begin
        flash_cs           <= 1'b1;
        flash_clk          <= 1'b0;
        flash_mosi         <= 1'b0;
        cache_write_enable <= '0;
        r_state            <= S_IDLE;
        ready              <= 1'b1;
      end else begin
        case (r_state)
          S_POWERUP: begin
            if (r_wait_cnt == c_WAIT_W'(c_WAIT_LAST)) begin
              r_state <= S_IDLE;
              ready   <= 1'b1;
            end else begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
            end
          end

          S_IDLE: begin
            if (start) begin
              r_dst       <= dst_addr;
              r_remaining <= byte_count;
              if (byte_count == '0) begin
                done <= 1'b1;
              end else begin
                ready      <= 1'b0;
                flash_cs   <= 1'b0;
                flash_mosi <= c_CMD_READ[7];
                r_tx       <= {c_CMD_READ[6:0], src_addr, 1'b0};
                r_div_cnt  <= '0;
                r_bit_cnt  <= '0;
                r_lane     <= '0;
                r_word     <= '0;
                r_state    <= S_CMD;
              end
            end
          end

          S_CMD, S_ADDR, S_READ: begin
            if (!w_half_done) begin
              r_div_cnt <= r_div_cnt + 1'b1;
            end else begin
              r_div_cnt <= '0;
              if (!flash_clk) begin
                flash_clk <= 1'b1;
                r_rx      <= {r_rx[6:0], flash_miso};
              end else begin
                flash_clk <= 1'b0;
                r_bit_cnt <= r_bit_cnt + 1'b1;
                if (r_state == S_CMD) begin
                  flash_mosi <= r_tx[31];
                  r_tx       <= r_tx << 1;
                  if (r_bit_cnt == 5'd7) r_state <= S_ADDR;
                end else if (r_state == S_ADDR) begin
                  if (r_bit_cnt == 5'd31) begin
                    flash_mosi <= 1'b0;
                    r_bit_cnt  <= '0;
                    r_state    <= S_READ;
                  end else begin
                    flash_mosi <= r_tx[31];
                    r_tx       <= r_tx << 1;
                  end
                end else if (r_bit_cnt == 5'd7) begin
                  r_bit_cnt   <= '0;
                  r_word      <= w_word_next;
                  r_remaining <= r_remaining - LEN_WIDTH'(1);
                  if (r_lane == c_LANE_W'(c_BYTES - 1) || r_remaining == LEN_WIDTH'(1)) begin
                    cache_write_enable <= w_strobe;
                    cache_data_in      <= w_word_next;
                    cache_address      <= r_dst;
                    r_lane             <= '0;
                    r_state            <= S_WRITE;
                  end else begin
                    r_lane <= r_lane + 1'b1;
                  end
                end
              end
            end
          end

          // flash_clk stays low here; the flash keeps its read position.
          S_WRITE: begin
            if (!cache_busy) begin
              cache_write_enable <= '0;
              r_dst              <= r_dst + ADDR_WIDTH'(c_BYTES);
              r_word             <= '0;
              r_div_cnt          <= '0;
              if (r_remaining == '0) begin
                flash_cs <= 1'b1;
                done     <= 1'b1;
                r_state  <= S_FINISH;
              end else begin
                r_state <= S_READ;
              end
            end
          end

          S_FINISH: begin
            r_state <= S_IDLE;
            ready   <= 1'b1;
          end

          default: begin
            r_state <= S_POWERUP;
            ready   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_loader.sv
// ============================================================================
// Module  : tb_spi_flash_loader
// Brief   : Directed bench for spi_flash_loader with flash and cache models.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_spi_flash_loader;

  localparam int c_DW = 32;
  localparam int c_AW = 32;
  localparam int c_LW = 24;
  localparam int c_CD = 3;
  localparam int c_SW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [23:0]     src_addr = '0;
  logic [c_AW-1:0] dst_addr = '0;
  logic [c_LW-1:0] byte_count = '0;
  logic            ready, done;
  logic [c_AW-1:0] cache_address;
  logic [c_DW-1:0] cache_data_in;
  logic [3:0]      cache_write_enable;
  logic            cache_busy = 1'b0;
  logic            flash_clk, flash_mosi, flash_cs;
  logic            flash_miso = 1'b0;

  always #5 clk = ~clk;

  spi_flash_loader #(
    .DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .LEN_WIDTH(c_LW),
    .CLK_DIV(c_CD), .STARTUP_WAIT(c_SW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .byte_count(byte_count),
    .ready(ready), .done(done),
    .cache_address(cache_address), .cache_data_in(cache_data_in),
    .cache_write_enable(cache_write_enable), .cache_busy(cache_busy),
    .flash_clk(flash_clk), .flash_mosi(flash_mosi), .flash_cs(flash_cs),
    .flash_miso(flash_miso)
  );

  // Flash model: mode 0, byte at address i is i[7:0], 24-bit address wrap.
  int          fl_bits = 0;
  logic [31:0] fl_sh = '0;
  logic [31:0] mosi_cap = '0;
  int          fl_idx;
  logic [23:0] fl_a;

  always @(negedge flash_cs) begin
    fl_bits = 0;
    fl_sh   = '0;
  end

  always @(posedge flash_clk) begin
    if (!flash_cs) begin
      if (fl_bits < 32) fl_sh = {fl_sh[30:0], flash_mosi};
      fl_bits++;
      if (fl_bits == 32) mosi_cap = fl_sh;
    end
  end

  always @(negedge flash_clk) begin
    if (!flash_cs && fl_bits >= 32) begin
      fl_idx     = fl_bits - 32;
      fl_a       = fl_sh[23:0] + 24'(fl_idx / 8);
      flash_miso = fl_a[7 - (fl_idx % 8)];
    end
  end

  // Cache model and monitors
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  wr_t  wq[$];
  int   done_cnt = 0, cs_low_cnt = 0, hp_bad = 0, hp_seen = 0, run = 0;
  logic prev_fclk = 1'b0;
  bit   rand_busy = 0, force_busy = 0;

  always @(posedge clk) begin
    #1;
    if (force_busy) cache_busy = 1'b1;
    else            cache_busy = rand_busy && ($urandom_range(0, 3) == 0);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (cache_write_enable != 4'h0 && !cache_busy)
        wq.push_back('{cache_address, cache_data_in, cache_write_enable});
      if (done) done_cnt++;
      if (!flash_cs) cs_low_cnt++;
      if (flash_clk === prev_fclk) run++;
      else begin
        if (prev_fclk === 1'b1) begin
          hp_seen++;
          if (run != c_CD) hp_bad++;
        end
        run = 1;
      end
      prev_fclk = flash_clk;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ready) begin ok = 1; break; end
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
  endtask

  task automatic kick(input logic [23:0] s, input logic [31:0] d, input logic [23:0] n);
    @(posedge clk); #1;
    src_addr = s; dst_addr = d; byte_count = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  typedef struct {
    logic [23:0] src;
    logic [31:0] dst;
    logic [23:0] cnt;
    int          nw;
    logic [31:0] ea[2];
    logic [31:0] ed[2];
    logic [3:0]  es[2];
  } vec_t;

  function automatic vec_t mk(logic [23:0] s, logic [31:0] d, logic [23:0] n, int nw,
                              logic [31:0] a0, logic [31:0] d0, logic [3:0] s0,
                              logic [31:0] a1, logic [31:0] d1, logic [3:0] s1);
    vec_t v;
    v.src = s; v.dst = d; v.cnt = n; v.nw = nw;
    v.ea[0] = a0; v.ed[0] = d0; v.es[0] = s0;
    v.ea[1] = a1; v.ed[1] = d1; v.es[1] = s1;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    bit ok;
    wait_ready(200, ok);
    chk("ready_before_start", 64'(ok), 64'd1);
    wq.delete();
    done_cnt = 0; cs_low_cnt = 0; mosi_cap = '0;
    kick(v.src, v.dst, v.cnt);
    wait_done(8000, ok);
    chk("done_seen", 64'(ok), 64'd1);
    chk("cs_high_at_done", 64'(flash_cs), 64'd1);
    repeat (3) @(negedge clk);
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("write_count", 64'(wq.size()), 64'(v.nw));
    for (int k = 0; k < v.nw && k < wq.size(); k++) begin
      chk("wr_addr", 64'(wq[k].a), 64'(v.ea[k]));
      chk("wr_data", 64'(wq[k].d), 64'(v.ed[k]));
      chk("wr_strb", 64'(wq[k].s), 64'(v.es[k]));
    end
    if (v.cnt != 0) chk("mosi_cmd_addr", 64'(mosi_cap), 64'({8'h03, v.src}));
    else            chk("cs_never_low", 64'(cs_low_cnt), 64'd0);
  endtask

  vec_t vecs[7];

  initial begin
    bit ok;
    int fz_bad;

    vecs[0] = mk(24'h000000, 32'h100, 24'd8, 2, 32'h100, 32'h03020100, 4'hF, 32'h104, 32'h07060504, 4'hF);
    vecs[1] = mk(24'h000005, 32'h000, 24'd3, 1, 32'h000, 32'h00070605, 4'h7, 32'h0, 32'h0, 4'h0);
    vecs[2] = mk(24'h000010, 32'h200, 24'd5, 2, 32'h200, 32'h13121110, 4'hF, 32'h204, 32'h00000014, 4'h1);
    vecs[3] = mk(24'h0000FE, 32'h040, 24'd4, 1, 32'h040, 32'h0100FFFE, 4'hF, 32'h0, 32'h0, 4'h0);
    vecs[4] = mk(24'hFFFFFE, 32'hFFFFFFFC, 24'd6, 2, 32'hFFFFFFFC, 32'h0100FFFE, 4'hF, 32'h0, 32'h00000302, 4'h3);
    vecs[5] = mk(24'h000000, 32'h080, 24'd0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0);
    vecs[6] = mk(24'h000033, 32'h008, 24'd1, 1, 32'h008, 32'h00000033, 4'h1, 32'h0, 32'h0, 4'h0);

    // Reset state and power-up wait
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cs", 64'(flash_cs), 64'd1);
    chk("rst_fclk", 64'(flash_clk), 64'd0);
    chk("rst_mosi", 64'(flash_mosi), 64'd0);
    chk("rst_we", 64'(cache_write_enable), 64'd0);
    chk("rst_addr", 64'(cache_address), 64'd0);
    chk("rst_data", 64'(cache_data_in), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (c_SW - 1) @(posedge clk);
    #1 chk("ready_before_wait_end", 64'(ready), 64'd0);
    @(posedge clk);
    #1 chk("ready_at_wait_end", 64'(ready), 64'd1);

    rand_busy = 1;
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // count=0: done exactly one cycle after start is sampled
    rand_busy = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    byte_count = '0; start = 1'b1;
    chk("zero_no_early_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("zero_done_next", 64'(done), 64'd1);
    chk("zero_cs_high", 64'(flash_cs), 64'd1);
    chk("zero_still_ready", 64'(ready), 64'd1);
    @(posedge clk); #1;
    chk("zero_done_one_cycle", 64'(done), 64'd0);

    // cache_busy held 20 cycles with a write pending
    wq.delete();
    done_cnt = 0; hp_bad = 0; hp_seen = 0;
    kick(24'h0, 32'h500, 24'd16);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (cache_write_enable != 4'h0) begin ok = 1; break; end
    end
    chk("busy_write_seen", 64'(ok), 64'd1);
    cache_busy = 1'b1; force_busy = 1;
    fz_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (flash_clk !== 1'b0 || flash_cs !== 1'b0 || cache_write_enable !== 4'hF) fz_bad++;
    end
    chk("busy_frozen", 64'(fz_bad), 64'd0);
    chk("busy_no_accept", 64'(wq.size()), 64'd0);
    force_busy = 0;
    wait_done(8000, ok);
    chk("busy_done_seen", 64'(ok), 64'd1);
    chk("busy_write_count", 64'(wq.size()), 64'd4);
    for (int k = 0; k < 4 && k < wq.size(); k++) begin
      logic [7:0] b0;
      b0 = 8'(4 * k);
      chk("busy_addr", 64'(wq[k].a), 64'(32'h500 + 32'(4 * k)));
      chk("busy_data", 64'(wq[k].d), 64'({b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0}));
    end
    chk("half_period_seen", 64'(hp_seen > 0), 64'd1);
    chk("half_period_len", 64'(hp_bad), 64'd0);

    // abort after two words of a 64-byte copy, then restart
    rand_busy = 1;
    wait_ready(200, ok);
    wq.delete();
    done_cnt = 0;
    kick(24'h0, 32'h300, 24'd64);
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (wq.size() >= 2) begin ok = 1; break; end
    end
    chk("abort_two_words", 64'(ok), 64'd1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_cs", 64'(flash_cs), 64'd1);
    chk("abort_fclk", 64'(flash_clk), 64'd0);
    chk("abort_we", 64'(cache_write_enable), 64'd0);
    chk("abort_ready", 64'(ready), 64'd1);
    repeat (60) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_writes", 64'(wq.size()), 64'd2);
    if (wq.size() > 0) chk("abort_first_data", 64'(wq[0].d), 64'h03020100);
    run_vec(mk(24'h000020, 32'h300, 24'd8, 2, 32'h300, 32'h23222120, 4'hF, 32'h304, 32'h27262524, 4'hF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
